// File: rtl/datapath_mul.sv
// Register file + integer ALU with a shift-add multiplier (NBITS+1 busy cycles) that owns writeback while Busy.
// Optional DP_MULHI_EN adds MULHU (opcode 1011); controller writes and MUL requests are dropped while Busy.
module datapath_mul #(
  parameter int NBITS      = 8,
  parameter int NREGS      = 32,
  parameter int WIDTH_ALUF = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [$clog2(NREGS)-1:0]  RS1,
  input  logic [$clog2(NREGS)-1:0]  RS2,
  input  logic [$clog2(NREGS)-1:0]  RD,
  input  logic signed [NBITS-1:0]   IMM,
  input  logic [WIDTH_ALUF-1:0]     ALUControl,
  input  logic                      ALUSrc,
  input  logic                      MemtoReg,
  input  logic                      RegWrite,
  input  logic                      link,
  input  logic [NBITS-1:0]          pclink,
  output logic [NBITS-1:0]          PCReg,
  output logic                      Zero,
  output logic                      Neg,
  output logic                      Carry,
  output logic                      Overflow,
  output logic                      Busy,
  output logic                      Done,
  output logic [NBITS-3:0]          Address,
  output logic [NBITS-1:0]          WriteData,
  input  logic [NBITS-1:0]          ReadData
);

  localparam int RW = $clog2(NREGS);
  localparam int SW = $clog2(NBITS);
  localparam int CW = $clog2(NBITS);
`ifdef DP_MULHI_EN
  localparam int AW = 2 * NBITS;
`else
  localparam int AW = NBITS;
`endif
  localparam logic [RW:0] NREGS_W = (RW+1)'(NREGS);

  localparam logic [WIDTH_ALUF-1:0] OP_ADD   = WIDTH_ALUF'(0);
  localparam logic [WIDTH_ALUF-1:0] OP_SUB   = WIDTH_ALUF'(1);
  localparam logic [WIDTH_ALUF-1:0] OP_SLT   = WIDTH_ALUF'(2);
  localparam logic [WIDTH_ALUF-1:0] OP_SLTU  = WIDTH_ALUF'(3);
  localparam logic [WIDTH_ALUF-1:0] OP_AND   = WIDTH_ALUF'(4);
  localparam logic [WIDTH_ALUF-1:0] OP_OR    = WIDTH_ALUF'(5);
  localparam logic [WIDTH_ALUF-1:0] OP_XOR   = WIDTH_ALUF'(6);
  localparam logic [WIDTH_ALUF-1:0] OP_SLL   = WIDTH_ALUF'(7);
  localparam logic [WIDTH_ALUF-1:0] OP_SRL   = WIDTH_ALUF'(8);
  localparam logic [WIDTH_ALUF-1:0] OP_SRA   = WIDTH_ALUF'(9);
  localparam logic [WIDTH_ALUF-1:0] OP_MUL   = WIDTH_ALUF'(10);
`ifdef DP_MULHI_EN
  localparam logic [WIDTH_ALUF-1:0] OP_MULHU = WIDTH_ALUF'(11);
`endif

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  logic [NBITS-1:0] regs [NREGS];
  logic [NBITS-1:0] src_a, rdata2, src_b;
  logic [NBITS:0]   diff_ext;
  logic [NBITS-1:0] sub_res;
  logic [SW-1:0]    shamt;
  logic [NBITS-1:0] alu_result;
  logic [NBITS-1:0] wb_data;
  logic [NBITS-1:0] mul_wb;
  logic             is_mul, is_mulhu, mul_op;
  logic             issue, single_we, mul_we;
  logic             ovf_int, neg_int, carry_int;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    mcand;
  logic [NBITS-1:0] mplier;
  logic [RW-1:0]    rd_lat;
`ifdef DP_MULHI_EN
  logic             hi_sel;
`endif

  // Indices beyond NREGS (non power-of-two sizes) read as zero like x0.
  always_comb begin
    src_a = '0;
    if (RS1 != '0 && {1'b0, RS1} < NREGS_W) src_a = regs[RS1];
  end

  always_comb begin
    rdata2 = '0;
    if (RS2 != '0 && {1'b0, RS2} < NREGS_W) rdata2 = regs[RS2];
  end

  assign src_b = ALUSrc ? IMM : rdata2;

  // Flags come from SrcA - SrcB regardless of the selected operation.
  assign diff_ext  = {1'b0, src_a} + {1'b0, ~src_b} + {{NBITS{1'b0}}, 1'b1};
  assign sub_res   = diff_ext[NBITS-1:0];
  assign carry_int = diff_ext[NBITS];
  assign ovf_int   = (src_a[NBITS-1] ^ src_b[NBITS-1]) & (sub_res[NBITS-1] ^ src_a[NBITS-1]);
  assign neg_int   = sub_res[NBITS-1] ^ ovf_int;
  assign shamt     = src_b[SW-1:0];

  assign Zero     = (src_a == src_b);
  assign Carry    = carry_int;
  assign Overflow = ovf_int;
  assign Neg      = neg_int;

  always_comb begin
    alu_result = src_a + src_b;
    case (ALUControl)
      OP_ADD:  alu_result = src_a + src_b;
      OP_SUB:  alu_result = sub_res;
      OP_SLT:  alu_result = {{(NBITS-1){1'b0}}, neg_int};
      OP_SLTU: alu_result = {{(NBITS-1){1'b0}}, ~carry_int};
      OP_AND:  alu_result = src_a & src_b;
      OP_OR:   alu_result = src_a | src_b;
      OP_XOR:  alu_result = src_a ^ src_b;
      OP_SLL:  alu_result = src_a << shamt;
      OP_SRL:  alu_result = src_a >> shamt;
      OP_SRA:  alu_result = $signed(src_a) >>> shamt;
      default: alu_result = src_a + src_b;
    endcase
  end

  assign PCReg     = src_a;
  assign WriteData = rdata2;
  assign Address   = alu_result[NBITS-1:2];
  assign wb_data   = link ? pclink : (MemtoReg ? ReadData : alu_result);

  assign is_mul = (ALUControl == OP_MUL);
`ifdef DP_MULHI_EN
  assign is_mulhu = (ALUControl == OP_MULHU);
  assign mul_wb   = hi_sel ? acc[2*NBITS-1:NBITS] : acc[NBITS-1:0];
`else
  assign is_mulhu = 1'b0;
  assign mul_wb   = acc;
`endif
  assign mul_op = is_mul | is_mulhu;

  assign issue     = (state == S_IDLE) && RegWrite && mul_op;
  assign single_we = (state == S_IDLE) && RegWrite && !mul_op &&
                     (RD != '0) && ({1'b0, RD} < NREGS_W);
  assign mul_we    = (state == S_DONE) && (rd_lat != '0) && ({1'b0, rd_lat} < NREGS_W);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (mul_we) begin
      regs[rd_lat] <= mul_wb;
    end else if (single_we) begin
      regs[RD] <= wb_data;
    end
  end

  // One multiplier bit per cycle, LSB first; multiplicand shifts up alongside.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rd_lat <= '0;
`ifdef DP_MULHI_EN
      hi_sel <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (issue) begin
            state  <= S_MUL;
            Busy   <= 1'b1;
            cnt    <= CW'(NBITS-1);
            acc    <= '0;
            mcand  <= AW'(src_a);
            mplier <= src_b;
            rd_lat <= RD;
`ifdef DP_MULHI_EN
            hi_sel <= is_mulhu;
`endif
          end
        end
        S_MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == '0) begin
            state <= S_DONE;
            Done  <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_mul.sv
// Bench for datapath_mul: arithmetic reference model plus directed literal checks and random traffic.
module tb_datapath_mul;
  localparam int N = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic [7:0] imm = '0;
  logic [3:0] aluc = '0;
  logic       alusrc = 1'b0, memtoreg = 1'b0, regwrite = 1'b0, link = 1'b0;
  logic [7:0] pclink = '0, readdata = '0;
  logic [7:0] pcreg, writedata;
  logic       zero, neg, carry, ovf, busy, done;
  logic [5:0] address;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  datapath_mul dut (
    .clock(clock), .reset(reset),
    .RS1(rs1), .RS2(rs2), .RD(rd), .IMM(imm),
    .ALUControl(aluc), .ALUSrc(alusrc), .MemtoReg(memtoreg), .RegWrite(regwrite),
    .link(link), .pclink(pclink),
    .PCReg(pcreg), .Zero(zero), .Neg(neg), .Carry(carry), .Overflow(ovf),
    .Busy(busy), .Done(done), .Address(address), .WriteData(writedata),
    .ReadData(readdata)
  );

  // Reference model: architectural registers and a pending-multiply countdown.
  logic [7:0] mregs [32] = '{default: 8'h00};
  int busy_cnt = 0;
  int m_prod   = 0;
  int m_rd     = 0;
  bit m_hi     = 1'b0;

  function automatic int sgn(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  function automatic bit is_mul_code(input int op);
`ifdef DP_MULHI_EN
    return (op == 10) || (op == 11);
`else
    return (op == 10);
`endif
  endfunction

  function automatic int alu_ref(input int op, input int a, input int b);
    int sh;
    sh = b % 8;
    case (op)
      1:       return (a - b) & 255;
      2:       return (sgn(a) < sgn(b)) ? 1 : 0;
      3:       return (a < b) ? 1 : 0;
      4:       return a & b;
      5:       return a | b;
      6:       return a ^ b;
      7:       return (a << sh) & 255;
      8:       return a >> sh;
      9:       return (sgn(a) >>> sh) & 255;
      default: return (a + b) & 255;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clock or posedge reset) begin
    int a, b;
    if (reset) begin
      foreach (mregs[i]) mregs[i] = 8'h00;
      busy_cnt = 0;
    end else begin
      a = int'(mregs[rs1]);
      b = alusrc ? int'(imm) : int'(mregs[rs2]);
      if (busy_cnt > 0) begin
        if (busy_cnt == 1 && m_rd != 0)
          mregs[m_rd] = 8'(m_hi ? (m_prod >> 8) & 255 : m_prod & 255);
        busy_cnt--;
      end else if (regwrite && is_mul_code(int'(aluc))) begin
        busy_cnt = N + 1;
        m_prod   = a * b;
        m_rd     = int'(rd);
        m_hi     = (aluc == 4'd11);
      end else if (regwrite && rd != 5'd0) begin
        mregs[rd] = link ? pclink : (memtoreg ? readdata : 8'(alu_ref(int'(aluc), a, b)));
      end
    end
  end

  always @(negedge clock) begin
    int a, b, d;
    a = int'(mregs[rs1]);
    b = alusrc ? int'(imm) : int'(mregs[rs2]);
    d = sgn(a) - sgn(b);
    chk("pcreg", int'(pcreg), a);
    chk("writedata", int'(writedata), int'(mregs[rs2]));
    chk("zero", int'(zero), (a == b) ? 1 : 0);
    chk("carry", int'(carry), (a >= b) ? 1 : 0);
    chk("neg", int'(neg), (sgn(a) < sgn(b)) ? 1 : 0);
    chk("overflow", int'(ovf), (d > 127 || d < -128) ? 1 : 0);
    chk("busy", int'(busy), (busy_cnt > 0) ? 1 : 0);
    chk("done", int'(done), (busy_cnt == 1) ? 1 : 0);
    if (!is_mul_code(int'(aluc)))
      chk("address", int'(address), alu_ref(int'(aluc), a, b) >> 2);
  end

  task automatic drive(input int op, input int r1, input int r2, input int d, input int im,
                       input bit src, input bit wr, input bit m2r, input bit lk);
    @(posedge clock);
    #1;
    aluc     = 4'(op);
    rs1      = 5'(r1);
    rs2      = 5'(r2);
    rd       = 5'(d);
    imm      = 8'(im);
    alusrc   = src;
    regwrite = wr;
    memtoreg = m2r;
    link     = lk;
    pclink   = 8'($urandom);
    readdata = 8'($urandom);
  endtask

  task automatic nop(input int r1);
    drive(0, r1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic peek(input int r, input int exp, input string nm);
    nop(r);
    #1;
    chk(nm, int'(pcreg), exp);
  endtask

  initial begin
    int busy_n, done_at, done_n;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

    drive(0, 0, 0, 1, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1, 1, 0, 0, 7, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("sub_x1", int'(pcreg), 5);
    chk("sub_zero", int'(zero), 0);
    chk("sub_neg", int'(neg), 1);
    chk("sub_carry", int'(carry), 0);
    chk("sub_ovf", int'(ovf), 0);
    chk("sub_addr", int'(address), 8'hFE >> 2);

    drive(0, 0, 0, 2, 11, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 0, 1, 13, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(10, 1, 2, 3, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    busy_n = 0; done_at = 0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 1) drive(0, 0, 0, 4, 99, 1'b1, 1'b1, 1'b0, 1'b0);
      else nop(3);
      #1;
      if (busy) busy_n++;
      if (done) done_at = i;
    end
    chk("mul_busy_cycles", busy_n, 9);
    chk("mul_done_cycle", done_at, 9);
    peek(3, 8'h8F, "mul_x3");
    peek(4, 0, "busy_write_dropped");
    chk("model_x3", int'(mregs[3]), 8'h8F);

    drive(0, 0, 0, 7, 20, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(10, 7, 7, 4, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (9) nop(0);
    drive(11, 7, 7, 5, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (12) nop(0);
    peek(4, 8'h90, "mul_x4");
`ifdef DP_MULHI_EN
    peek(5, 8'h01, "mulhu_x5");
`else
    peek(5, 8'h28, "op11_add_x5");
`endif

    drive(0, 0, 0, 0, 9, 1'b1, 1'b1, 1'b0, 1'b0);
    peek(0, 0, "x0_zero");
    drive(10, 1, 2, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    done_n = 0;
    for (int i = 0; i < 12; i++) begin
      nop(3);
      #1;
      if (done) done_n++;
    end
    chk("mul_rd0_done", done_n, 1);
    peek(3, 8'h8F, "mul_rd0_x3");

    drive(10, 7, 7, 6, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) nop(0);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_done", int'(done), 0);
    rs1 = 5'd3;
    #1;
    chk("rst_mid_x3", int'(pcreg), 0);
    @(posedge clock);
    #1 reset = 1'b0;
    peek(6, 0, "rst_x6");
    drive(0, 0, 0, 1, 13, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 0, 2, 11, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(10, 1, 2, 6, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (11) nop(0);
    peek(6, 8'h8F, "post_rst_mul_x6");

    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 255), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0));
    end
    nop(0);
    @(posedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/datapath_mul.md
Name: datapath_mul

Overview:
Next-generation datapath: parametrised register file plus full integer ALU, with a multi-cycle shift-add multiplier that owns the writeback port while running.
- Sits between the controller and data memory/cache, same position as the current datapath.
- Adds MemtoReg writeback, signed/unsigned flags and a Busy/Done handshake so the controller stalls on MUL.

Parameters:
NBITS, 8, datapath/register width (>=4)
NREGS, 32, number of registers; x0 hardwired to 0
WIDTH_ALUF, 4, ALUControl width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
RS1, RS2, RD  in  $clog2(NREGS) each  source/destination register indices
IMM  in  NBITS signed  immediate
ALUControl  in  WIDTH_ALUF  operation select
ALUSrc  in  1  1: SrcB=IMM, 0: SrcB=reg[RS2]
MemtoReg  in  1  writeback selects ReadData
RegWrite  in  1  write enable for single-cycle ops
link  in  1  writeback selects pclink (overrides MemtoReg)
pclink  in  NBITS  PC value for link
PCReg  out  NBITS  =SrcA, to PC
Zero, Neg, Carry, Overflow  out  1 each  compare flags of SrcA-SrcB
Busy  out  1  multiplier running
Done  out  1  one-cycle pulse in the multiplier writeback cycle
Address  out  NBITS-2  ALUResult[NBITS-1:2]
WriteData  out  NBITS  reg[RS2]
ReadData  in  NBITS  data from memory

Behaviour:
- Reset (async, active-high): all registers 0, FSM IDLE, Busy=0, Done=0. A reset during MUL aborts it; no write.
- Reads are combinational. Reg 0 reads 0 and is never written.
- ALUControl encoding: 0000 ADD, 0001 SUB, 0010 SLT (signed), 0011 SLTU, 0100 AND, 0101 OR, 0110 XOR, 0111 SLL, 1000 SRL, 1001 SRA, 1010 MUL; all others ADD.
- Shift amount is SrcB[$clog2(NBITS)-1:0].
- Flags are always computed from SrcA + ~SrcB + 1, independent of ALUControl:
  - Zero: SrcA==SrcB.
  - Carry: carry-out; 1 when SrcA>=SrcB unsigned.
  - Overflow: signed overflow of the subtraction.
  - Neg: signed SrcA<SrcB, i.e. sign XOR Overflow.
- Result mux: link ? pclink : MemtoReg ? ReadData : ALUResult.
- Single-cycle write: reg[RD]<=Result at the edge where RegWrite=1, Busy=0, ALUControl!=MUL.
- FSM IDLE->MUL: in IDLE, ALUControl==MUL and RegWrite=1 issues.
  - At that edge, latch SrcA, SrcB and RD; counter=NBITS-1.
- FSM MUL: each cycle, add the multiplicand to the accumulator if the current multiplier LSB is 1, then shift.
  - At counter==0 go to DONE; otherwise decrement.
- FSM DONE: Done=1; low NBITS of the product written to latched RD (dropped if RD==0); then IDLE.
- Busy = (state!=IDLE).
- Latency: issue edge E0; Busy high cycles 1..NBITS+1; Done in cycle NBITS+1; register visible after edge E(NBITS+1).
- While Busy: controller RegWrite and MUL requests are ignored (no queueing). PCReg, flags, Address and WriteData stay live from current RS1/RS2.
- Back-to-back MUL: the next issue is accepted in the first IDLE cycle after DONE.

Optional Feature:
DP_MULHI_EN
- Defined: ALUControl 1011 = MULHU. Same FSM and latency as MUL, but writes product[2*NBITS-1:NBITS]. The accumulator is 2*NBITS wide.
- Undefined: 1011 decodes as ADD. The accumulator may be NBITS wide.

Test Plan:
- Reset asserted mid-cycle -> immediately Busy=0, Done=0, all regs read 0.
- ADD RS1=0, IMM=5, ALUSrc=1, RD=1, RegWrite -> x1=5.
  - Then SUB x1, IMM=7 -> Zero=0, Neg=1, Carry=0, Overflow=0, Result=0xFE.
- MUL with x1=13, x2=11, RD=3 -> Busy high 9 cycles, Done in cycle 9, x3=0x8F.
  - RegWrite to x4 during Busy is ignored.
- MUL 20*20 into x4 -> x4=0x90.
  - With DP_MULHI_EN, MULHU of the same operands into x5 -> x5=0x01.
- ADD RD=0, IMM=9 -> x0 still reads 0. MUL with RD=0 -> Done pulses, no register changes.
- Reset at cycle 4 of a MUL to x6 -> Busy drops immediately, x6=0.
  - A fresh MUL issued after reset completes correctly.
